// File: rtl/decode_queue.sv
// decode_queue: RV32I(+M) decode FIFO between fetch and execute with legality checks, trap locking and flush
package decode_queue_pkg;
  typedef struct packed {
    logic jump;
    logic branch;
    logic jalr;
  } id_if_ctrl_t;
  typedef struct packed {
    logic [1:0] alu_src1;
    logic       alu_src2;
    logic [2:0] alu_op;
    logic       alu_op_alt;
  } ex_ctrl_t;
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_mode;
  } mem_ctrl_t;
  typedef struct packed {
    logic [1:0] writeback_src;
    logic       reg_write;
  } wb_ctrl_t;
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } reg_ids_t;
  localparam logic [1:0] SRC1_RS1 = 2'd0, SRC1_PC = 2'd1, SRC1_ZERO = 2'd2;
  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2;
  localparam logic [1:0] TRAP_NONE = 2'd0, TRAP_ILLEGAL = 2'd1, TRAP_ECALL = 2'd2, TRAP_EBREAK = 2'd3;
endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset_n,
  input  logic                        i_Flush,
  input  logic                        i_FetchValid,
  output logic                        o_FetchReady,
  input  logic [31:0]                 i_InstructionWord,
  input  logic [PC_WIDTH-1:0]         i_PC,
  output logic                        o_DecodeValid,
  input  logic                        i_DecodeReady,
  output logic [PC_WIDTH-1:0]         o_PC,
  output id_if_ctrl_t                 o_ID_IF_Control,
  output ex_ctrl_t                    o_EX_Control,
  output mem_ctrl_t                   o_MEM_Control,
  output wb_ctrl_t                    o_WB_Control,
  output reg_ids_t                    o_RegisterIDs,
  output logic [31:0]                 o_Immediate,
  output logic                        o_MulDiv,
  output logic [1:0]                  o_TrapCause,
  output logic [$clog2(DEPTH):0]      o_Count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    id_if_ctrl_t         ctl_if;
    ex_ctrl_t            ctl_ex;
    mem_ctrl_t           ctl_mem;
    wb_ctrl_t            ctl_wb;
    reg_ids_t            regs;
    logic [31:0]         imm;
    logic                mul_div;
    logic [1:0]          cause;
  } entry_t;
  logic [31:0] w, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [2:0] f3;
  logic [6:0] f7;
  logic legal;
  logic [1:0] sys_cause;
  entry_t d, head;
  entry_t slots [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic trap_lock, push, pop;
  assign w = i_InstructionWord;
  assign f3 = w[14:12];
  assign f7 = w[31:25];
  assign imm_i = {{20{w[31]}}, w[31:20]};
  assign imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
  assign imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  assign imm_u = {w[31:12], 12'b0};
  assign imm_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  always_comb begin
    d = '0;
    legal = 1'b1;
    sys_cause = TRAP_NONE;
    d.pc = i_PC;
    d.regs = '{rs1: w[19:15], rs2: w[24:20], rd: w[11:7]};
    case (w[6:0])
      7'b0110111: begin
        d.ctl_ex.alu_src1 = SRC1_ZERO;
        d.ctl_ex.alu_src2 = 1'b1;
        d.ctl_wb.reg_write = 1'b1;
        d.imm = imm_u;
      end
      7'b0010111: begin
        d.ctl_ex.alu_src1 = SRC1_PC;
        d.ctl_ex.alu_src2 = 1'b1;
        d.ctl_wb.reg_write = 1'b1;
        d.imm = imm_u;
      end
      7'b1101111: begin
        d.ctl_if.jump = 1'b1;
        d.ctl_ex.alu_src1 = SRC1_PC;
        d.ctl_ex.alu_src2 = 1'b1;
        d.ctl_wb = '{writeback_src: WB_PC4, reg_write: 1'b1};
        d.imm = imm_j;
      end
      7'b1100111: begin
        d.ctl_if = '{jump: 1'b1, branch: 1'b0, jalr: 1'b1};
        d.ctl_ex.alu_src2 = 1'b1;
        d.ctl_wb = '{writeback_src: WB_PC4, reg_write: 1'b1};
        d.imm = imm_i;
        legal = f3 == 3'd0;
      end
      7'b1100011: begin
        d.ctl_if.branch = 1'b1;
        d.ctl_ex.alu_op_alt = 1'b1;
        d.imm = imm_b;
        legal = f3[2:1] != 2'b01;
      end
      7'b0000011: begin
        d.ctl_mem = '{mem_read: 1'b1, mem_write: 1'b0, mem_mode: f3};
        d.ctl_ex.alu_src2 = 1'b1;
        d.ctl_wb = '{writeback_src: WB_MEM, reg_write: 1'b1};
        d.imm = imm_i;
        legal = f3[1:0] != 2'b11 && f3 != 3'd6;
      end
      7'b0100011: begin
        d.ctl_mem = '{mem_read: 1'b0, mem_write: 1'b1, mem_mode: f3};
        d.ctl_ex.alu_src2 = 1'b1;
        d.imm = imm_s;
        legal = !f3[2] && f3[1:0] != 2'b11;
      end
      7'b0010011: begin
        d.ctl_ex.alu_src2 = 1'b1;
        d.ctl_ex.alu_op = f3;
        d.ctl_ex.alu_op_alt = f3 == 3'd5 && w[30];
        d.ctl_wb.reg_write = 1'b1;
        d.imm = imm_i;
        legal = f3 == 3'd1 ? f7 == 7'h00 : f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      end
      7'b0110011: begin
        d.ctl_ex.alu_op = f3;
        d.ctl_wb.reg_write = 1'b1;
        d.ctl_ex.alu_op_alt = f7 != 7'h01 && w[30];
        d.mul_div = f7 == 7'h01 && ENABLE_M;
        legal = f7 == 7'h01 ? ENABLE_M : f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      end
      7'b1110011: begin
        legal = w == 32'h0000_0073 || w == 32'h0010_0073;
        sys_cause = w[20] ? TRAP_EBREAK : TRAP_ECALL;
      end
      default: legal = 1'b0;
    endcase
    d.cause = legal ? sys_cause : TRAP_ILLEGAL;
    if (d.cause != TRAP_NONE) begin
      d.ctl_if = '0;
      d.ctl_mem = '0;
      d.ctl_wb = '0;
      d.imm = '0;
      d.mul_div = 1'b0;
    end
  end
  assign o_FetchReady = count < CW'(DEPTH) && !trap_lock;
  assign o_DecodeValid = count != '0;
  assign push = i_FetchValid && o_FetchReady && !i_Flush;
  assign pop = o_DecodeValid && i_DecodeReady && !i_Flush;
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      trap_lock <= 1'b0;
    end else if (i_Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      trap_lock <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
      trap_lock <= trap_lock || (push && d.cause != TRAP_NONE);
    end
  end
  always_ff @(posedge i_Clock) begin
    if (push) slots[wr_ptr] <= d;
  end
  assign head = o_DecodeValid ? slots[rd_ptr] : '0;
  assign o_PC = head.pc;
  assign o_ID_IF_Control = head.ctl_if;
  assign o_EX_Control = head.ctl_ex;
  assign o_MEM_Control = head.ctl_mem;
  assign o_WB_Control = head.ctl_wb;
  assign o_RegisterIDs = head.regs;
  assign o_Immediate = head.imm;
  assign o_MulDiv = head.mul_div;
  assign o_TrapCause = head.cause;
  assign o_Count = count;
endmodule
